// File: rtl/otp_digit_engine.sv
// otp_digit_engine
//   Receives the truncated HOTP value bit-serially (MSB first). It converts the
//   value to BCD with a sequential double-dabble that does one shift per clock.
//   It keeps the low DIGITS decimal digits and presents one digit at a time.
//   The digit is chosen either by sel or by a built-in multiplex scanner.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-high
//   start      in   pulse: drop current result, begin loading a new value
//   bit_in     in   serial value bit, MSB first
//   bit_valid  in   bit_in is valid this cycle
//   sel        in   [3:0] manual digit select, 0 = leftmost displayed digit
//   scan_en    in   1 = auto-cycle digits, 0 = manual sel
//   bcd        out  [3:0] selected digit, 4'hF = blank
//   digit_idx  out  [3:0] index of the digit on bcd
//   ready      out  result valid
//   busy       out  loading or converting
module otp_digit_engine #(
    parameter int BITS     = 31,
    parameter int DIGITS   = 6,
    parameter int SCAN_DIV = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic [3:0] sel,
    input  logic       scan_en,
    output logic [3:0] bcd,
    output logic [3:0] digit_idx,
    output logic       ready,
    output logic       busy
);

    localparam int              CW       = 6;
    localparam int              PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]   LAST_CNT = CW'(BITS - 1);
    localparam logic [PW-1:0]   PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [3:0]      IDX_LAST = 4'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [39:0] dabble_adjust(input logic [39:0] b);
        logic [39:0] r;
        r = 40'd0;
        for (int i = 0; i < 10; i++) begin
            if (b[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = b[i*4 +: 4];
            end
        end
        return r;
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CW-1:0]      cnt_r;
    logic [BITS-1:0]    value_r;
    logic [39:0]        bcd_r;
    logic               scan_en_r;
    logic [PW-1:0]      pre_r;
    logic [3:0]         scan_idx_r;

    logic               cnt_clr_s;
    logic               cnt_inc_s;
    logic               load_shift_s;
    logic               conv_step_s;
    logic               bcd_clr_s;
    logic [BITS-1:0]    load_val_s;
    logic [40+BITS-1:0] conv_shift_s;
    logic [3:0]         idx_s;
    logic [3:0]         dig_s;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state and datapath strobes; start overrides everything, including
    // a same-cycle bit_valid (that bit is dropped).
    always_comb begin
        state_nxt_s  = state_r;
        cnt_clr_s    = 1'b0;
        cnt_inc_s    = 1'b0;
        load_shift_s = 1'b0;
        conv_step_s  = 1'b0;
        bcd_clr_s    = 1'b0;
        if (start) begin
            state_nxt_s = ST_LOAD;
            cnt_clr_s   = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_LOAD: begin
                    if (bit_valid) begin
                        load_shift_s = 1'b1;
                        if (cnt_r == LAST_CNT) begin
                            state_nxt_s = ST_CONVERT;
                            cnt_clr_s   = 1'b1;
                            bcd_clr_s   = 1'b1;
                        end else begin
                            cnt_inc_s   = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end
                ST_CONVERT: begin
                    conv_step_s = 1'b1;
                    if (cnt_r == LAST_CNT) begin
                        state_nxt_s = ST_DONE;
                        cnt_clr_s   = 1'b1;
                    end else begin
                        cnt_inc_s   = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_DONE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Next values for the serial load and for one combined {bcd,value} dabble step.
    always_comb begin
        load_val_s   = (value_r << 1) | BITS'(bit_in);
        conv_shift_s = {dabble_adjust(bcd_r), value_r} << 1;
    end

    // Bit/cycle counter, value shift register and BCD accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= '0;
            value_r <= '0;
            bcd_r   <= 40'd0;
        end else begin
            if (cnt_clr_s) begin
                cnt_r <= '0;
            end else if (cnt_inc_s) begin
                cnt_r <= cnt_r + 6'd1;
            end
            if (load_shift_s) begin
                value_r <= load_val_s;
            end else if (conv_step_s) begin
                value_r <= conv_shift_s[BITS-1:0];
            end
            if (bcd_clr_s) begin
                bcd_r <= 40'd0;
            end else if (conv_step_s) begin
                bcd_r <= conv_shift_s[40+BITS-1:BITS];
            end
        end
    end

    // Display scanner, independent of the FSM. scan_en is registered so that
    // the outputs depend only on registers (and sel). Dropping scan_en clears
    // the prescaler and index immediately. The first count waits one cycle
    // for the registered enable, so digit 0 is shown for a full SCAN_DIV period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_en_r  <= 1'b0;
            pre_r      <= '0;
            scan_idx_r <= 4'd0;
        end else begin
            scan_en_r <= scan_en;
            if (!scan_en) begin
                pre_r      <= '0;
                scan_idx_r <= 4'd0;
            end else if (scan_en_r) begin
                if (pre_r == PRE_LAST) begin
                    pre_r <= '0;
                    if (scan_idx_r == IDX_LAST) begin
                        scan_idx_r <= 4'd0;
                    end else begin
                        scan_idx_r <= scan_idx_r + 4'd1;
                    end
                end else begin
                    pre_r <= pre_r + PW'(1);
                end
            end
        end
    end

    // Output selection. Displayed digit k is BCD nibble DIGITS-1-k. Indices
    // >= DIGITS match no nibble and stay blank.
    always_comb begin
        idx_s = scan_en_r ? scan_idx_r : sel;
        dig_s = 4'hF;
        for (int k = 0; k < DIGITS; k++) begin
            dig_s = (idx_s == 4'(k)) ? bcd_r[(DIGITS-1-k)*4 +: 4] : dig_s;
        end
        ready     = (state_r == ST_DONE);
        busy      = (state_r == ST_LOAD) | (state_r == ST_CONVERT);
        digit_idx = idx_s;
        bcd       = ready ? dig_s : 4'hF;
    end

endmodule
